// File: rtl/gpu_circle_pkg.sv
// Shared definitions for the circle sequencer slice.
// Holds the default geometry and colour widths, the inter-octant gap length
// and the sequencer state encoding used by gpu_circle_seq.
package gpu_circle_pkg;

  localparam int CHANNEL_BITS   = 8;
  localparam int WIDTH_BITS     = 10;
  localparam int HEIGHT_BITS    = 9;
  localparam int SCREEN_W       = 320;
  localparam int SCREEN_H       = 240;
  localparam int COLOR_BITS     = 3 * CHANNEL_BITS;
  localparam int GAP_CYCLES_DEF = 2;
  localparam int PX_CNT_BITS    = 16;
  localparam int NUM_OCTANTS    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_GAP    = 3'd3,
    ST_FIN    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/gpu_circle_seq_pixel_clip.sv
// gpu_pixel_clip: registered capture / clip / write stage for rasterised pixels.
// A candidate presented on cand_valid_i appears one cycle later on the
// framebuffer port. Coordinates outside the screen suppress the write strobe;
// negative results of the rasteriser's subtraction arrive as large unsigned
// values and are rejected by the same compare.
//
// Ports:
//   clk, n_rst        clock, async active-low reset
//   cand_valid_i      candidate pixel this cycle
//   x_i, y_i          candidate coordinate
//   color_i           colour to write
//   px_we_o           one-cycle framebuffer write strobe
//   px_x_o, px_y_o    write address
//   px_color_o        write data
//   cnt_inc_o         pixel counter increment enable (one per write)
module gpu_pixel_clip
  import gpu_circle_pkg::*;
#(
  parameter int W_BITS   = WIDTH_BITS,
  parameter int H_BITS   = HEIGHT_BITS,
  parameter int SCR_W    = SCREEN_W,
  parameter int SCR_H    = SCREEN_H,
  parameter int COL_BITS = COLOR_BITS
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                cand_valid_i,
  input  logic [W_BITS-1:0]   x_i,
  input  logic [H_BITS-1:0]   y_i,
  input  logic [COL_BITS-1:0] color_i,
  output logic                px_we_o,
  output logic [W_BITS-1:0]   px_x_o,
  output logic [H_BITS-1:0]   px_y_o,
  output logic [COL_BITS-1:0] px_color_o,
  output logic                cnt_inc_o
);

  // One extra bit so a screen size equal to 2**W_BITS still compares correctly.
  localparam logic [W_BITS:0] SCR_W_L = (W_BITS+1)'(SCR_W);
  localparam logic [H_BITS:0] SCR_H_L = (H_BITS+1)'(SCR_H);

  logic                in_screen;
  logic                px_we_q, px_we_d;
  logic [W_BITS-1:0]   px_x_q, px_x_d;
  logic [H_BITS-1:0]   px_y_q, px_y_d;
  logic [COL_BITS-1:0] px_color_q, px_color_d;

  assign in_screen = ({1'b0, x_i} < SCR_W_L) && ({1'b0, y_i} < SCR_H_L);

  always_comb begin
    px_we_d    = cand_valid_i && in_screen;
    px_x_d     = px_x_q;
    px_y_d     = px_y_q;
    px_color_d = px_color_q;
    if (cand_valid_i) begin
      px_x_d     = x_i;
      px_y_d     = y_i;
      px_color_d = color_i;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      px_we_q    <= 1'b0;
      px_x_q     <= '0;
      px_y_q     <= '0;
      px_color_q <= '0;
    end else begin
      px_we_q    <= px_we_d;
      px_x_q     <= px_x_d;
      px_y_q     <= px_y_d;
      px_color_q <= px_color_d;
    end
  end

  assign px_we_o    = px_we_q;
  assign px_x_o     = px_x_q;
  assign px_y_o     = px_y_q;
  assign px_color_o = px_color_q;
  assign cnt_inc_o  = px_we_q;

endmodule

// File: rtl/gpu_circle_seq.sv
// gpu_circle_seq: circle command sequencer around the octant rasteriser.
// Accepts one circle command, runs the rasteriser for octants 0..7 in order,
// writes every in-screen rasterised pixel to the framebuffer and pulses
// done_o after octant 7.
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// LAUNCH| oct_start high, waiting for the rasteriser to report busy
// RUN   | oct_start high, rasteriser producing pixels until oct_done
// GAP   | oct_start low for GAP_CYCLES so the next octant sees a rising edge
// FIN   | one-cycle done_o pulse, then back to IDLE
//
// Ports:
//   clk, n_rst                      clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_xc/cmd_yc/cmd_rad/cmd_color circle command fields
//   abort                           cancel the running circle, no done pulse
//   oct_xc/oct_yc/oct_rad/oct_sel   latched command and octant to rasteriser
//   oct_start                       rasteriser start level
//   oct_busy/oct_done/oct_x/oct_y   rasteriser status and pixel coordinate
//   px_we/px_x/px_y/px_color        framebuffer write port
//   busy_o/done_o                   circle in progress / completion pulse
//   px_count                        pixels written for current/last circle
module gpu_circle_seq
  import gpu_circle_pkg::*;
#(
  parameter int W_BITS     = WIDTH_BITS,
  parameter int H_BITS     = HEIGHT_BITS,
  parameter int SCR_W      = SCREEN_W,
  parameter int SCR_H      = SCREEN_H,
  parameter int COL_BITS   = COLOR_BITS,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int CNT_BITS   = PX_CNT_BITS
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [W_BITS-1:0]   cmd_xc,
  input  logic [H_BITS-1:0]   cmd_yc,
  input  logic [W_BITS-1:0]   cmd_rad,
  input  logic [COL_BITS-1:0] cmd_color,
  input  logic                abort,
  output logic [W_BITS-1:0]   oct_xc,
  output logic [H_BITS-1:0]   oct_yc,
  output logic [W_BITS-1:0]   oct_rad,
  output logic [2:0]          oct_sel,
  output logic                oct_start,
  input  logic                oct_busy,
  input  logic                oct_done,
  input  logic [W_BITS-1:0]   oct_x,
  input  logic [H_BITS-1:0]   oct_y,
  output logic                px_we,
  output logic [W_BITS-1:0]   px_x,
  output logic [H_BITS-1:0]   px_y,
  output logic [COL_BITS-1:0] px_color,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_BITS-1:0] px_count
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  seq_state_e          state_q, state_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [2:0]          oct_sel_q, oct_sel_d;
  logic [W_BITS-1:0]   xc_q, xc_d;
  logic [H_BITS-1:0]   yc_q, yc_d;
  logic [W_BITS-1:0]   rad_q, rad_d;
  logic [COL_BITS-1:0] color_q, color_d;
  logic [CNT_BITS-1:0] px_count_q, px_count_d;

  logic accept;
  logic last_oct;
  logic octant_active;
  logic abort_act;
  logic gap_exit;
  logic cand_valid;
  logic cnt_inc;

  assign accept        = (state_q == ST_IDLE) && cmd_valid;
  assign last_oct      = (oct_sel_q == 3'(NUM_OCTANTS - 1));
  assign octant_active = (state_q == ST_LAUNCH) || (state_q == ST_RUN);
  assign abort_act     = abort && (state_q != ST_IDLE);
  assign gap_exit      = (state_q == ST_GAP) && (gap_cnt_q == '0);
  // A pixel sampled in the abort cycle is dropped.
  assign cand_valid    = octant_active && oct_busy && !abort;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        // A very short octant may report busy and done together.
        if (oct_busy) begin
          if (oct_done) state_d = last_oct ? ST_FIN : ST_GAP;
          else          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (oct_done) state_d = last_oct ? ST_FIN : ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_LAUNCH;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort_act) state_d = ST_IDLE;
  end

  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if ((state_d == ST_GAP) && (state_q != ST_GAP)) begin
      gap_cnt_d = GAP_LOAD;
    end else if ((state_q == ST_GAP) && (gap_cnt_q != '0)) begin
      gap_cnt_d = gap_cnt_q - 1'b1;
    end
  end

  // Command fields and octant index only move outside LAUNCH/RUN, so the
  // rasteriser's combinational mapping is stable while oct_start is high.
  always_comb begin
    oct_sel_d  = oct_sel_q;
    xc_d       = xc_q;
    yc_d       = yc_q;
    rad_d      = rad_q;
    color_d    = color_q;
    px_count_d = px_count_q;
    if (accept) begin
      oct_sel_d  = 3'd0;
      xc_d       = cmd_xc;
      yc_d       = cmd_yc;
      rad_d      = cmd_rad;
      color_d    = cmd_color;
      px_count_d = '0;
    end else begin
      if (gap_exit && !abort) oct_sel_d = oct_sel_q + 3'd1;
      if (cnt_inc && !(&px_count_q)) px_count_d = px_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      gap_cnt_q  <= '0;
      oct_sel_q  <= 3'd0;
      xc_q       <= '0;
      yc_q       <= '0;
      rad_q      <= '0;
      color_q    <= '0;
      px_count_q <= '0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      oct_sel_q  <= oct_sel_d;
      xc_q       <= xc_d;
      yc_q       <= yc_d;
      rad_q      <= rad_d;
      color_q    <= color_d;
      px_count_q <= px_count_d;
    end
  end

  gpu_pixel_clip #(
    .W_BITS   (W_BITS),
    .H_BITS   (H_BITS),
    .SCR_W    (SCR_W),
    .SCR_H    (SCR_H),
    .COL_BITS (COL_BITS)
  ) u_pixel_clip (
    .clk          (clk),
    .n_rst        (n_rst),
    .cand_valid_i (cand_valid),
    .x_i          (oct_x),
    .y_i          (oct_y),
    .color_i      (color_q),
    .px_we_o      (px_we),
    .px_x_o       (px_x),
    .px_y_o       (px_y),
    .px_color_o   (px_color),
    .cnt_inc_o    (cnt_inc)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign oct_start = octant_active;
  assign busy_o    = octant_active || (state_q == ST_GAP);
  assign done_o    = (state_q == ST_FIN) && !abort;
  assign oct_xc    = xc_q;
  assign oct_yc    = yc_q;
  assign oct_rad   = rad_q;
  assign oct_sel   = oct_sel_q;
  assign px_count  = px_count_q;

endmodule

// File: tb/tb_gpu_circle_seq.sv
// Directed bench for gpu_circle_seq with a behavioural octant rasteriser.
// Rasteriser point lists per radius (first octant, trX >= trY):
//   r=0: (0,0)   r=1: (1,0),(0,1)   r=5: (5,0),(5,1),(5,2),(4,3)
// Octant k maps (trX,trY) to the screen as:
//   0:(+X,+Y) 1:(+Y,+X) 2:(-Y,+X) 3:(-X,+Y) 4:(-X,-Y) 5:(-Y,-X) 6:(+Y,-X) 7:(+X,-Y)
module tb_gpu_circle_seq;
  import gpu_circle_pkg::*;

  localparam int WB = WIDTH_BITS;
  localparam int HB = HEIGHT_BITS;
  localparam int CB = COLOR_BITS;
  localparam int NB = PX_CNT_BITS;

  logic          clk;
  logic          n_rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [WB-1:0] cmd_xc;
  logic [HB-1:0] cmd_yc;
  logic [WB-1:0] cmd_rad;
  logic [CB-1:0] cmd_color;
  logic          abort;
  logic [WB-1:0] oct_xc;
  logic [HB-1:0] oct_yc;
  logic [WB-1:0] oct_rad;
  logic [2:0]    oct_sel;
  logic          oct_start;
  logic          oct_busy;
  logic          oct_done;
  logic [WB-1:0] oct_x;
  logic [HB-1:0] oct_y;
  logic          px_we;
  logic [WB-1:0] px_x;
  logic [HB-1:0] px_y;
  logic [CB-1:0] px_color;
  logic          busy_o;
  logic          done_o;
  logic [NB-1:0] px_count;

  gpu_circle_seq dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_xc    (cmd_xc),
    .cmd_yc    (cmd_yc),
    .cmd_rad   (cmd_rad),
    .cmd_color (cmd_color),
    .abort     (abort),
    .oct_xc    (oct_xc),
    .oct_yc    (oct_yc),
    .oct_rad   (oct_rad),
    .oct_sel   (oct_sel),
    .oct_start (oct_start),
    .oct_busy  (oct_busy),
    .oct_done  (oct_done),
    .oct_x     (oct_x),
    .oct_y     (oct_y),
    .px_we     (px_we),
    .px_x      (px_x),
    .px_y      (px_y),
    .px_color  (px_color),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .px_count  (px_count)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural rasteriser ----------------
  function automatic int npts(input int r);
    case (r)
      0:       npts = 1;
      1:       npts = 2;
      default: npts = 4;
    endcase
  endfunction

  function automatic int pt_x(input int r, input int i);
    int tx5[4] = '{5, 5, 5, 4};
    if (r == 0)      pt_x = 0;
    else if (r == 1) pt_x = (i == 0) ? 1 : 0;
    else             pt_x = tx5[i];
  endfunction

  function automatic int pt_y(input int r, input int i);
    int ty5[4] = '{0, 1, 2, 3};
    if (r == 0)      pt_y = 0;
    else if (r == 1) pt_y = (i == 0) ? 0 : 1;
    else             pt_y = ty5[i];
  endfunction

  int   r_st, r_idx, r_n, r_x, r_y;
  logic r_prev;

  task automatic put_point();
    int tx, ty;
    logic [WB-1:0] xc;
    logic [HB-1:0] yc;
    tx = pt_x(int'(oct_rad), r_idx);
    ty = pt_y(int'(oct_rad), r_idx);
    xc = oct_xc;
    yc = oct_yc;
    case (oct_sel)
      3'd0: begin oct_x = xc + WB'(tx); oct_y = yc + HB'(ty); end
      3'd1: begin oct_x = xc + WB'(ty); oct_y = yc + HB'(tx); end
      3'd2: begin oct_x = xc - WB'(ty); oct_y = yc + HB'(tx); end
      3'd3: begin oct_x = xc - WB'(tx); oct_y = yc + HB'(ty); end
      3'd4: begin oct_x = xc - WB'(tx); oct_y = yc - HB'(ty); end
      3'd5: begin oct_x = xc - WB'(ty); oct_y = yc - HB'(tx); end
      3'd6: begin oct_x = xc + WB'(ty); oct_y = yc - HB'(tx); end
      default: begin oct_x = xc + WB'(tx); oct_y = yc - HB'(ty); end
    endcase
  endtask

  initial begin
    oct_busy = 1'b0;
    oct_done = 1'b0;
    oct_x    = '0;
    oct_y    = '0;
    r_st     = 0;
    r_idx    = 0;
    r_n      = 0;
    r_prev   = 1'b0;
    forever begin
      @(negedge clk);
      oct_done = 1'b0;
      if (!oct_start) begin
        oct_busy = 1'b0;
        r_st     = 0;
      end else if (!r_prev) begin
        r_n   = npts(int'(oct_rad));
        r_idx = 0;
        put_point();
        oct_busy = 1'b1;
        r_st     = 1;
      end else if (r_st == 1) begin
        r_idx++;
        if (r_idx < r_n) begin
          put_point();
        end else begin
          oct_busy = 1'b0;
          oct_done = 1'b1;
          r_st     = 2;
        end
      end
      r_prev = oct_start;
    end
  end

  // ---------------- monitor ----------------
  logic [WB-1:0] wx [256];
  logic [HB-1:0] wy [256];
  logic [CB-1:0] wc [256];
  int   wtot = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   done_cyc = 0;
  int   busy_rise_cyc = 0;
  int   low_run = 0;
  logic had_high = 1'b0;
  logic m_prev_start = 1'b0;
  logic m_prev_busy = 1'b0;
  logic [2:0]    m_prev_sel = '0;
  logic [WB-1:0] m_prev_xc = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (px_we) begin
        wx[wtot % 256] = px_x;
        wy[wtot % 256] = px_y;
        wc[wtot % 256] = px_color;
        wtot++;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy_o && !m_prev_busy) busy_rise_cyc = cyc;
      if (oct_start && m_prev_start) begin
        check("sel_stable", 32'(oct_sel), 32'(m_prev_sel));
        check("xc_stable", 32'(oct_xc), 32'(m_prev_xc));
      end
      if (!busy_o) begin
        had_high = 1'b0;
        low_run  = 0;
      end else if (oct_start) begin
        if (had_high && !m_prev_start) check("gap_len", 32'(low_run), 32'(GAP_CYCLES_DEF));
        had_high = 1'b1;
        low_run  = 0;
      end else begin
        low_run++;
      end
      m_prev_start = oct_start;
      m_prev_busy  = busy_o;
      m_prev_sel   = oct_sel;
      m_prev_xc    = oct_xc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic send_cmd(input int x, input int y, input int r, input logic [CB-1:0] c);
    step();
    cmd_valid = 1'b1;
    cmd_xc    = WB'(x);
    cmd_yc    = HB'(y);
    cmd_rad   = WB'(r);
    cmd_color = c;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      step();
      k++;
    end
    check("done_timeout", 32'(done_cnt >= target), 32'd1);
    step();
  endtask

  int base, d0, w_abort;

  initial begin
    n_rst     = 1'b0;
    cmd_valid = 1'b0;
    cmd_xc    = '0;
    cmd_yc    = '0;
    cmd_rad   = '0;
    cmd_color = '0;
    abort     = 1'b0;

    // reset state
    #23;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_oct_start", 32'(oct_start), 32'd0);
    check("rst_px_we", 32'(px_we), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_px_count", 32'(px_count), 32'd0);
    check("rst_oct_sel", 32'(oct_sel), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_ready", 32'(cmd_ready), 32'd1);
      check("idle_we", 32'(px_we), 32'd0);
      check("idle_busy", 32'(busy_o), 32'd0);
      check("idle_done", 32'(done_o), 32'd0);
    end

    // rad=0 at (100,100): 8 identical writes
    base = wtot;
    d0 = done_cnt;
    send_cmd(100, 100, 0, 24'h123456);
    wait_done(d0 + 1, 400);
    check("r0_writes", 32'(wtot - base), 32'd8);
    check("r0_count", 32'(px_count), 32'd8);
    check("r0_done_pulses", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("r0_x", 32'(wx[(base + i) % 256]), 32'd100);
      check("r0_y", 32'(wy[(base + i) % 256]), 32'd100);
      check("r0_color", 32'(wc[(base + i) % 256]), 32'h123456);
    end

    // rad=1 at (50,60): 2 writes per octant
    base = wtot;
    d0 = done_cnt;
    send_cmd(50, 60, 1, 24'h00ff00);
    wait_done(d0 + 1, 400);
    check("r1_writes", 32'(wtot - base), 32'd16);
    check("r1_count", 32'(px_count), 32'd16);
    check("r1_o0a_x", 32'(wx[(base + 0) % 256]), 32'd51);
    check("r1_o0a_y", 32'(wy[(base + 0) % 256]), 32'd60);
    check("r1_o0b_x", 32'(wx[(base + 1) % 256]), 32'd50);
    check("r1_o0b_y", 32'(wy[(base + 1) % 256]), 32'd61);
    check("r1_o4a_x", 32'(wx[(base + 8) % 256]), 32'd49);
    check("r1_o4a_y", 32'(wy[(base + 8) % 256]), 32'd60);
    check("r1_o4b_x", 32'(wx[(base + 9) % 256]), 32'd50);
    check("r1_o4b_y", 32'(wy[(base + 9) % 256]), 32'd59);

    // clipping near the left edge: 32 candidates, 10 wrap below zero
    base = wtot;
    d0 = done_cnt;
    send_cmd(2, 120, 5, 24'hff0000);
    wait_done(d0 + 1, 600);
    check("clip_count", 32'(px_count), 32'd22);
    check("clip_writes", 32'(wtot - base), 32'd22);
    for (int i = 0; i < 22; i++) begin
      check("clip_x_range", 32'(wx[(base + i) % 256] < WB'(320)), 32'd1);
    end

    // abort during octant 3
    d0 = done_cnt;
    send_cmd(160, 120, 5, 24'h0000ff);
    begin
      int k;
      k = 0;
      while (!(oct_sel == 3'd3 && oct_busy && oct_start) && k < 600) begin
        step();
        k++;
      end
      check("abort_reach_oct3", 32'(k < 600), 32'd1);
    end
    step();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_oct_start", 32'(oct_start), 32'd0);
    check("abort_px_we", 32'(px_we), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_idle", 32'(cmd_ready), 32'd1);
    w_abort = wtot;
    for (int i = 0; i < 8; i++) step();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_no_writes", 32'(wtot - w_abort), 32'd0);

    // a normal command after abort
    base = wtot;
    d0 = done_cnt;
    send_cmd(30, 40, 0, 24'habcdef);
    wait_done(d0 + 1, 400);
    check("post_abort_writes", 32'(wtot - base), 32'd8);
    check("post_abort_count", 32'(px_count), 32'd8);
    check("post_abort_x", 32'(wx[(base + 7) % 256]), 32'd30);

    // back-to-back: cmd_valid held across FIN
    base = wtot;
    d0 = done_cnt;
    step();
    cmd_valid = 1'b1;
    cmd_xc    = WB'(10);
    cmd_yc    = HB'(10);
    cmd_rad   = WB'(1);
    cmd_color = 24'h111111;
    step();
    check("b2b_ready_busy", 32'(cmd_ready), 32'd0);
    check("b2b_busy", 32'(busy_o), 32'd1);
    cmd_xc    = WB'(20);
    cmd_yc    = HB'(20);
    cmd_rad   = WB'(0);
    cmd_color = 24'h222222;
    begin
      int k;
      k = 0;
      while (done_cnt < d0 + 1 && k < 400) begin
        step();
        k++;
      end
      check("b2b_first_done", 32'(done_cnt - d0), 32'd1);
      k = 0;
      while (!busy_o && k < 6) begin
        step();
        k++;
      end
      check("b2b_second_accept", 32'(busy_o), 32'd1);
    end
    cmd_valid = 1'b0;
    check("b2b_turnaround", 32'(busy_rise_cyc - done_cyc), 32'd2);
    wait_done(d0 + 2, 400);
    check("b2b_writes", 32'(wtot - base), 32'd24);
    check("b2b_count", 32'(px_count), 32'd8);
    check("b2b_first_x", 32'(wx[base % 256]), 32'd11);
    check("b2b_last_x", 32'(wx[(base + 23) % 256]), 32'd20);
    check("b2b_last_y", 32'(wy[(base + 23) % 256]), 32'd20);

    // reset in the middle of a circle
    send_cmd(200, 100, 5, 24'h333333);
    for (int i = 0; i < 12; i++) step();
    check("mid_busy_before", 32'(busy_o), 32'd1);
    n_rst = 1'b0;
    #1;
    check("mid_rst_oct_start", 32'(oct_start), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_px_we", 32'(px_we), 32'd0);
    check("mid_rst_count", 32'(px_count), 32'd0);
    check("mid_rst_xc", 32'(oct_xc), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    step();
    n_rst = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
